pcg_req_arbiter: RTL and testbench

Controller that shares one PCG generator datapath (LCG state plus output permutation) among NREQ requesters. It sequences seeding, discards warm-up outputs, grants one requester per cycle in round-robin order, and tags every returned word with its requester ID. It sits between the generator instance and consumer blocks and owns the generator's load and step controls.

---
 rtl/pcg_req_arbiter.sv | 97 +++++++++
 tb/tb_pcg_req_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pcg_req_arbiter.sv
// pcg_req_arbiter: seeds, warms up and round-robin shares one PCG generator among NREQ requesters
module pcg_req_arbiter #(
  parameter int NREQ = 4,
  parameter int GEN_LAT = 2,
  parameter int WARMUP = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     seed_in,
  input  logic            seed_load,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd_out,
  output logic            rnd_valid,
  output logic [IW-1:0]   rnd_id,
  output logic            busy,
  output logic [31:0]     gen_seed,
  output logic            gen_load,
  output logic            gen_step,
  input  logic [31:0]     gen_data
);
  typedef enum logic [2:0] {IDLE, LOAD, WARM, RUN, DRAIN} state_t;
  state_t state, nxt;
  logic [31:0] seed_reg, seed_nxt, hold_out;
  logic [7:0] warm_cnt;
  logic [IW-1:0] rr_ptr, gid, gnt_id, hold_id;
  logic [IW:0] k;
  logic found, grant;
  logic [GEN_LAT-1:0] tv;
  logic [GEN_LAT*IW-1:0] tid;
  always_comb begin
    seed_nxt = seed_load ? seed_in : seed_reg;
    nxt = state;
    case (state)
      IDLE:    nxt = seed_load ? LOAD : IDLE;
      LOAD:    nxt = seed_load ? LOAD : WARM;
      WARM:    nxt = seed_load ? LOAD : (warm_cnt == 8'd1 ? RUN : WARM);
      RUN:     nxt = seed_load ? DRAIN : RUN;
      DRAIN:   nxt = (!seed_load && tv == '0) ? LOAD : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // first requester at or after rr_ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    gid = '0;
    k = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = {1'b0, rr_ptr} + (IW+1)'(i);
      k = k >= (IW+1)'(NREQ) ? k - (IW+1)'(NREQ) : k;
      if (!found && req[k[IW-1:0]]) begin
        found = 1'b1;
        gid = k[IW-1:0];
      end
    end
    grant = found && nxt == RUN;
  end
  always_comb begin
    rnd_valid = tv[GEN_LAT-1];
    rnd_id = rnd_valid ? tid[GEN_LAT*IW-1 -: IW] : hold_id;
    rnd_out = rnd_valid ? gen_data : hold_out;
    busy = state != RUN;
  end
  // outputs are registered from the next-state decision so they line up with the new state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      seed_reg <= '0;
      warm_cnt <= '0;
      rr_ptr <= '0;
      gnt <= '0;
      gnt_id <= '0;
      gen_seed <= '0;
      gen_load <= 1'b0;
      gen_step <= 1'b0;
      tv <= '0;
      tid <= '0;
      hold_out <= '0;
      hold_id <= '0;
    end else begin
      state <= nxt;
      seed_reg <= seed_nxt;
      warm_cnt <= state == LOAD ? 8'(WARMUP) : warm_cnt - 8'(state == WARM);
      rr_ptr <= grant ? (gid == IW'(NREQ - 1) ? '0 : gid + 1'b1) : rr_ptr;
      gnt <= grant ? NREQ'(1) << gid : '0;
      gnt_id <= gid;
      gen_load <= nxt == LOAD;
      gen_seed <= nxt == LOAD ? seed_nxt : gen_seed;
      gen_step <= nxt == WARM || grant;
      tv <= GEN_LAT'({tv, |gnt});
      tid <= (GEN_LAT*IW)'({tid, gnt_id});
      hold_out <= rnd_out;
      hold_id <= rnd_id;
    end
  end
endmodule

// File: tb/tb_pcg_req_arbiter.sv
// tb_pcg_req_arbiter: directed vectors against a +1-per-step generator model with 2-cycle latency
module tb_pcg_req_arbiter;
  logic clk = 1'b0, rst = 1'b0, seed_load = 1'b0;
  logic [31:0] seed_in = '0, rnd_out, gen_seed, gen_data;
  logic [3:0] req = '0, gnt;
  logic [1:0] rnd_id;
  logic rnd_valid, busy, gen_load, gen_step;
  logic [31:0] g_state = '0, g_dly = '0;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic vld;
    logic [1:0] id;
    logic [31:0] dat;
  } vec_t;
  vec_t tbl[16];
  pcg_req_arbiter #(.NREQ(4), .GEN_LAT(2), .WARMUP(8)) dut (
    .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load), .req(req),
    .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_id(rnd_id), .busy(busy),
    .gen_seed(gen_seed), .gen_load(gen_load), .gen_step(gen_step), .gen_data(gen_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (gen_load) g_state <= gen_seed;
    else if (gen_step) g_state <= g_state + 32'd1;
    g_dly <= g_state;
  end
  assign gen_data = g_dly;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    tbl[0]  = '{4'b1000, 4'b1000, 1'b0, 2'd0, 32'h19};
    tbl[1]  = '{4'b1111, 4'b0001, 1'b0, 2'd0, 32'h19};
    tbl[2]  = '{4'b1111, 4'b0010, 1'b1, 2'd3, 32'h1a};
    tbl[3]  = '{4'b1111, 4'b0100, 1'b1, 2'd0, 32'h1b};
    tbl[4]  = '{4'b1111, 4'b1000, 1'b1, 2'd1, 32'h1c};
    tbl[5]  = '{4'b1111, 4'b0001, 1'b1, 2'd2, 32'h1d};
    tbl[6]  = '{4'b1111, 4'b0010, 1'b1, 2'd3, 32'h1e};
    tbl[7]  = '{4'b1111, 4'b0100, 1'b1, 2'd0, 32'h1f};
    tbl[8]  = '{4'b1111, 4'b1000, 1'b1, 2'd1, 32'h20};
    tbl[9]  = '{4'b1010, 4'b0010, 1'b1, 2'd2, 32'h21};
    tbl[10] = '{4'b1010, 4'b1000, 1'b1, 2'd3, 32'h22};
    tbl[11] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 32'h23};
    tbl[12] = '{4'b1010, 4'b1000, 1'b1, 2'd3, 32'h24};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 32'h25};
    tbl[14] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 32'h26};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 2'd3, 32'h26};
    repeat (3) tick();
    chk("rst gnt", gnt, 0);
    chk("rst rnd_valid", rnd_valid, 0);
    chk("rst rnd_out", rnd_out, 0);
    chk("rst busy", busy, 1);
    chk("rst gen_load", gen_load, 0);
    chk("rst gen_step", gen_step, 0);
    chk("rst gen_seed", gen_seed, 0);
    rst = 1'b1;
    tick();
    chk("idle gen_load", gen_load, 0);
    seed_in = 32'h10;
    seed_load = 1'b1;
    tick();
    chk("load gen_load", gen_load, 1);
    chk("load gen_seed", gen_seed, 32'h10);
    chk("load gen_step", gen_step, 0);
    seed_load = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("warm%0d gen_step", i), gen_step, 1);
      chk($sformatf("warm%0d rnd_valid", i), rnd_valid, 0);
      chk($sformatf("warm%0d gnt", i), gnt, 0);
    end
    tick();
    chk("first gnt", gnt, 4'b0001);
    chk("first busy", busy, 0);
    req = 4'b0000;
    tick();
    chk("first lag valid", rnd_valid, 0);
    tick();
    chk("first valid", rnd_valid, 1);
    chk("first rnd_out", rnd_out, 32'h19);
    chk("first rnd_id", rnd_id, 0);
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("row%0d gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("row%0d gen_step", i), gen_step, tbl[i].gnt != 4'b0000);
      chk($sformatf("row%0d rnd_valid", i), rnd_valid, tbl[i].vld);
      chk($sformatf("row%0d rnd_id", i), rnd_id, tbl[i].id);
      chk($sformatf("row%0d rnd_out", i), rnd_out, tbl[i].dat);
      chk($sformatf("row%0d busy", i), busy, 0);
    end
    req = 4'b1111;
    tick();
    chk("pre-reseed gnt0", gnt, 4'b0001);
    tick();
    chk("pre-reseed gnt1", gnt, 4'b0010);
    seed_in = 32'h100;
    seed_load = 1'b1;
    tick();
    chk("reseed gnt", gnt, 0);
    chk("reseed busy", busy, 1);
    chk("reseed gen_step", gen_step, 0);
    chk("drain word0 valid", rnd_valid, 1);
    chk("drain word0 out", rnd_out, 32'h27);
    chk("drain word0 id", rnd_id, 0);
    seed_load = 1'b0;
    tick();
    chk("drain word1 valid", rnd_valid, 1);
    chk("drain word1 out", rnd_out, 32'h28);
    chk("drain word1 id", rnd_id, 1);
    chk("drain gnt", gnt, 0);
    tick();
    chk("drain empty valid", rnd_valid, 0);
    chk("drain empty gen_load", gen_load, 0);
    chk("drain hold out", rnd_out, 32'h28);
    tick();
    chk("reload gen_load", gen_load, 1);
    chk("reload gen_seed", gen_seed, 32'h100);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rewarm%0d gen_step", i), gen_step, 1);
      chk($sformatf("rewarm%0d gnt", i), gnt, 0);
      chk($sformatf("rewarm%0d rnd_valid", i), rnd_valid, 0);
    end
    tick();
    chk("reseed first gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    tick();
    chk("reseed word valid", rnd_valid, 1);
    chk("reseed word out", rnd_out, 32'h109);
    chk("reseed word id", rnd_id, 2);
    seed_in = 32'h50;
    seed_load = 1'b1;
    tick();
    chk("drain2 busy", busy, 1);
    seed_load = 1'b0;
    tick();
    chk("load50 gen_seed", gen_seed, 32'h50);
    tick();
    chk("warm50 gen_step", gen_step, 1);
    tick();
    seed_in = 32'h20;
    seed_load = 1'b1;
    tick();
    chk("warm reseed gen_load", gen_load, 1);
    chk("warm reseed gen_seed", gen_seed, 32'h20);
    chk("warm reseed gen_step", gen_step, 0);
    seed_in = 32'h30;
    tick();
    chk("load reseed gen_load", gen_load, 1);
    chk("load reseed gen_seed", gen_seed, 32'h30);
    seed_load = 1'b0;
    req = 4'b0001;
    repeat (8) tick();
    tick();
    chk("s5 gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    tick();
    chk("s5 valid", rnd_valid, 1);
    chk("s5 rnd_out", rnd_out, 32'h39);
    chk("s5 rnd_id", rnd_id, 0);
    req = 4'b1111;
    tick();
    chk("s6 gnt0", gnt, 4'b0010);
    tick();
    chk("s6 gnt1", gnt, 4'b0100);
    rst = 1'b0;
    #2;
    chk("async gnt", gnt, 0);
    chk("async rnd_valid", rnd_valid, 0);
    chk("async rnd_out", rnd_out, 0);
    chk("async rnd_id", rnd_id, 0);
    chk("async busy", busy, 1);
    chk("async gen_step", gen_step, 0);
    chk("async gen_load", gen_load, 0);
    chk("async gen_seed", gen_seed, 0);
    req = 4'b0000;
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post-rst%0d rnd_valid", i), rnd_valid, 0);
      chk($sformatf("post-rst%0d busy", i), busy, 1);
      chk($sformatf("post-rst%0d gnt", i), gnt, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
